// File: rtl/tg_packet_injector_pkg.sv
// Shared widths and field layouts for trace descriptors and flits.
// Descriptor: {measure, size, vc, dest, inj}. Flit: {flags, ts, dest, src_inj, oport, ovc}.
package tg_packet_injector_pkg;
    localparam int ADDR_WIDTH   = 8;
    localparam int TS_WIDTH     = 16;
    localparam int P_SIZE_WIDTH = 3;

    localparam int P_INJ_LSB     = 0;
    localparam int P_DEST_LSB    = P_INJ_LSB + TS_WIDTH;
    localparam int P_VC_WIDTH    = 4;
    localparam int P_VC_LSB      = P_DEST_LSB + ADDR_WIDTH;
    localparam int P_SIZE_LSB    = P_VC_LSB + P_VC_WIDTH;
    localparam int P_MEASURE_BIT = P_SIZE_LSB + P_SIZE_WIDTH;

    localparam int F_OVC_WIDTH   = 4;
    localparam int F_OPORT_WIDTH = 3;
    localparam int F_OVC_LSB     = 0;
    localparam int F_OPORT_LSB   = F_OVC_LSB + F_OVC_WIDTH;
    localparam int F_SRC_INJ_LSB = F_OPORT_LSB + F_OPORT_WIDTH;
    localparam int F_DEST_LSB    = F_SRC_INJ_LSB + TS_WIDTH;
    localparam int F_TS_LSB      = F_DEST_LSB + ADDR_WIDTH;
    localparam int F_FLAGS_LSB   = F_TS_LSB + TS_WIDTH;
    localparam int FLIT_WIDTH    = F_FLAGS_LSB + 3;

    // Largest packet is 1 << (2^P_SIZE_WIDTH - 1) flits, which needs 2^P_SIZE_WIDTH bits.
    localparam int REM_WIDTH = 1 << P_SIZE_WIDTH;

    function automatic logic [FLIT_WIDTH-1:0] pack_flit(
        input logic [2:0]             flags,
        input logic [TS_WIDTH-1:0]    ts,
        input logic [ADDR_WIDTH-1:0]  dest,
        input logic [TS_WIDTH-1:0]    src_inj,
        input logic [F_OVC_WIDTH-1:0] ovc
    );
        pack_flit = {flags, ts, dest, src_inj, {F_OPORT_WIDTH{1'b0}}, ovc};
    endfunction
endpackage

// File: rtl/tg_packet_injector_fifo.sv
// Descriptor FIFO: count-based full/empty, head entry visible combinationally.
module tg_packet_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign data_o  = mem_q[rd_q];

    always_comb begin
        wr_d  = wr_q + AW'(do_push);
        rd_d  = rd_q + AW'(do_pop);
        cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end
endmodule

// File: rtl/tg_packet_injector.sv
// Trace-driven flit injector: queues descriptors, expands each into head/body/tail
// flits, holds the head until its timestamp is reached, and stalls on the VC's full flag.
module tg_packet_injector
    import tg_packet_injector_pkg::*;
#(
    parameter int HADDR      = 0,
    parameter int NVCS       = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [TS_WIDTH-1:0]   sim_time,
    input  logic [31:0]           packet_in,
    input  logic                  packet_in_valid,
    output logic                  packet_request,
    input  logic [NVCS-1:0]       obuf_full,
    output logic [FLIT_WIDTH-1:0] flit_out,
    output logic                  flit_out_valid,
    output logic                  busy
);
    localparam int VC_W = $clog2(NVCS);
    localparam logic [ADDR_WIDTH-1:0] HADDR_A   = HADDR[ADDR_WIDTH-1:0];
    localparam logic [TS_WIDTH-1:0]   HADDR_EXT = {{(TS_WIDTH-ADDR_WIDTH){1'b0}}, HADDR_A};

    typedef enum logic [1:0] {IDLE = 2'd0, HEAD = 2'd1, BODY = 2'd2} state_e;

    state_e               state_q, state_d;
    logic [31:0]          pkt_q, pkt_d;
    logic [REM_WIDTH-1:0] rem_q, rem_d;

    logic                  fifo_full, fifo_empty, fifo_pop, fifo_push;
    logic [31:0]           fifo_head;
    logic [TS_WIDTH-1:0]   p_inj, t_diff;
    logic [ADDR_WIDTH-1:0] p_dest;
    logic [VC_W-1:0]       vc;
    logic                  p_measure, vc_full, time_ok, last, head_f, tail_f, inject;
    logic                  unused_pkt;

    assign packet_request = enable & ~fifo_full;
    assign fifo_push      = packet_request & packet_in_valid;

    tg_packet_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (fifo_push),
        .data_i  (packet_in),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign p_inj      = pkt_q[P_INJ_LSB +: TS_WIDTH];
    assign p_dest     = pkt_q[P_DEST_LSB +: ADDR_WIDTH];
    assign p_measure  = pkt_q[P_MEASURE_BIT];
    assign vc         = pkt_q[P_VC_LSB +: VC_W];
    assign vc_full    = obuf_full[vc];
    assign unused_pkt = ^pkt_q;

    // Wrap-safe "sim_time >= inj": the difference is non-negative in TS_WIDTH arithmetic.
    assign t_diff  = sim_time - p_inj;
    assign time_ok = ~t_diff[TS_WIDTH-1];
    assign last    = (rem_q == REM_WIDTH'(1));

    always_comb begin
        state_d  = state_q;
        pkt_d    = pkt_q;
        rem_d    = rem_q;
        fifo_pop = 1'b0;
        inject   = 1'b0;
        head_f   = 1'b0;
        tail_f   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pkt_d    = fifo_head;
                    rem_d    = REM_WIDTH'(1) << fifo_head[P_SIZE_LSB +: P_SIZE_WIDTH];
                    fifo_pop = 1'b1;
                    state_d  = HEAD;
                end
            end
            HEAD: begin
                head_f = 1'b1;
                tail_f = last;
                if (enable && time_ok && !vc_full) begin
                    inject  = 1'b1;
                    rem_d   = rem_q - REM_WIDTH'(1);
                    state_d = last ? IDLE : BODY;
                end
            end
            BODY: begin
                tail_f = last;
                // Bodies ignore enable so a started packet always completes.
                if (!vc_full) begin
                    inject = 1'b1;
                    rem_d  = rem_q - REM_WIDTH'(1);
                    if (last) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            pkt_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            pkt_q   <= pkt_d;
            rem_q   <= rem_d;
        end
    end

    assign flit_out_valid = inject;
    assign flit_out = pack_flit({head_f, tail_f, p_measure}, p_inj, p_dest,
                                head_f ? HADDR_EXT : p_inj, F_OVC_WIDTH'(vc));
    assign busy = (state_q != IDLE) | ~fifo_empty;
endmodule

// File: tb/tb_tg_packet_injector.sv
// Randomized and directed bench for tg_packet_injector against a flit-queue reference model.
module tb_tg_packet_injector;
    import tg_packet_injector_pkg::*;

    localparam int NVCS       = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int HADDR      = 'h5A;
    localparam int W          = 16;

    logic                  clock = 1'b0;
    logic                  reset, enable, packet_in_valid, packet_request, flit_out_valid, busy;
    logic [TS_WIDTH-1:0]   sim_time;
    logic [31:0]           packet_in;
    logic [NVCS-1:0]       obuf_full;
    logic [FLIT_WIDTH-1:0] flit_out;

    tg_packet_injector #(.HADDR(HADDR), .NVCS(NVCS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clock(clock), .reset(reset), .enable(enable), .sim_time(sim_time),
        .packet_in(packet_in), .packet_in_valid(packet_in_valid),
        .packet_request(packet_request), .obuf_full(obuf_full),
        .flit_out(flit_out), .flit_out_valid(flit_out_valid), .busy(busy)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk_desc(input bit meas, input int size, input int vc,
                                            input int dest, input int inj);
        logic [31:0] d;
        d = {meas, 3'(size), 4'(vc), 8'(dest), 16'(inj)};
        return d;
    endfunction

    // i-th flit of a packet, straight from the field rules.
    function automatic logic [FLIT_WIDTH-1:0] exp_flit(input logic [31:0] d, input int i);
        int n;
        bit h, t;
        logic [15:0] inj;
        n   = 1 << d[30:28];
        inj = d[15:0];
        h   = (i == 0);
        t   = (i == n - 1);
        return {h, t, d[31], inj, d[23:16], (h ? 16'(HADDR) : inj), 3'b000, 2'b00, d[25:24]};
    endfunction

    logic [FLIT_WIDTH-1:0] exp_q[$];
    bit mon_en = 0;

    task automatic expect_pkt(input logic [31:0] d);
        for (int i = 0; i < (1 << d[30:28]); i++) exp_q.push_back(exp_flit(d, i));
    endtask

    // Every accepted descriptor yields its flits in push order; nothing else may appear.
    always @(negedge clock) begin
        if (mon_en) begin
            int qn;
            logic [FLIT_WIDTH-1:0] e;
            logic [15:0] dt;
            qn = exp_q.size();
            chk("busy", busy, qn > 0);
            if (!enable) chk("req_when_disabled", packet_request, 0);
            if (qn == 0) chk("spurious_flit", flit_out_valid, 0);
            else if (flit_out_valid) begin
                e = exp_q.pop_front();
                chk("flit", flit_out, e);
                chk("vc_not_full", obuf_full[e[1:0]], 0);
                if (e[49]) begin
                    dt = sim_time - e[46:31];
                    chk("head_time_ok", dt[15], 0);
                    chk("head_enable", enable, 1);
                end
            end
            if (reset) exp_q.delete();
            else if (packet_request && packet_in_valid) expect_pkt(packet_in);
        end
    end

    logic                  s_vld[W], s_rst[W], s_tsset[W];
    logic [31:0]           s_desc[W];
    logic [NVCS-1:0]       s_ofull[W];
    logic [15:0]           s_ts[W];
    logic                  obs_v[W], obs_b[W], obs_r[W];
    logic [FLIT_WIDTH-1:0] obs_f[W];
    logic [15:0]           obs_ts[W];

    task automatic tick();
        @(posedge clock);
        #1;
        sim_time = sim_time + 16'd1;
    endtask

    task automatic clr_sched();
        for (int k = 0; k < W; k++) begin
            s_vld[k] = 0; s_rst[k] = 0; s_tsset[k] = 0;
            s_desc[k] = '0; s_ofull[k] = '0; s_ts[k] = '0;
        end
    endtask

    task automatic run_obs(input int n);
        for (int k = 0; k < n; k++) begin
            tick();
            packet_in_valid = s_vld[k];
            packet_in       = s_desc[k];
            obuf_full       = s_ofull[k];
            reset           = s_rst[k];
            if (s_tsset[k]) sim_time = s_ts[k];
            @(negedge clock);
            obs_v[k] = flit_out_valid; obs_f[k] = flit_out; obs_ts[k] = sim_time;
            obs_b[k] = busy; obs_r[k] = packet_request;
        end
    endtask

    function automatic logic [W-1:0] vpat(input int n);
        logic [W-1:0] v;
        v = '0;
        for (int k = 0; k < n; k++) v[k] = obs_v[k];
        return v;
    endfunction

    task automatic drain(input string tag);
        int c;
        c = 0;
        packet_in_valid = 0;
        obuf_full = '0;
        enable = 1;
        while ((exp_q.size() != 0 || busy) && c < 2000) begin
            tick();
            @(negedge clock);
            #1;
            c++;
        end
        chk(tag, c < 2000, 1);
    endtask

    logic [31:0] f_desc[6];
    logic [31:0] d;
    int acc, fell;
    bit rose;

    initial begin
        reset = 1; enable = 1; packet_in_valid = 0; packet_in = '0; obuf_full = '0; sim_time = '0;
        repeat (3) @(posedge clock);
        #1 reset = 0;
        @(negedge clock);
        chk("rst_valid", flit_out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_req", packet_request, 1);
        tick(); enable = 0;
        @(negedge clock);
        chk("rst_req_disabled", packet_request, 0);
        tick(); enable = 1;
        mon_en = 1;

        // 4-flit packet, timestamp already reached: head two cycles after the push edge.
        clr_sched();
        d = mk_desc(0, 2, 0, 'h33, 1000);
        s_vld[0] = 1; s_desc[0] = d; s_tsset[0] = 1; s_ts[0] = 16'd1000;
        run_obs(9);
        chk("t1_valid_pattern", vpat(9), 16'h003C);
        chk("t1_head_flags", obs_f[2][49:47], 3'b100);
        chk("t1_tail_flags", obs_f[5][49:47], 3'b010);
        chk("t1_head_src", obs_f[2][22:7], 16'h005A);
        chk("t1_body_src", obs_f[3][22:7], 16'd1000);
        chk("t1_busy_during", obs_b[4], 1);
        chk("t1_busy_after", obs_b[6], 0);

        // Two single-flit packets back-to-back: one IDLE cycle between them.
        clr_sched();
        s_vld[0] = 1; s_desc[0] = mk_desc(1, 0, 2, 'h21, 2000);
        s_vld[1] = 1; s_desc[1] = mk_desc(1, 0, 1, 'h22, 2000);
        s_tsset[0] = 1; s_ts[0] = 16'd2000;
        run_obs(7);
        chk("t2_valid_pattern", vpat(7), 16'h0014);
        chk("t2_single_flags_a", obs_f[2][49:47], 3'b111);
        chk("t2_single_flags_b", obs_f[4][49:47], 3'b111);

        // Head held until sim_time reaches 100.
        clr_sched();
        s_vld[0] = 1; s_desc[0] = mk_desc(1, 0, 1, 'h11, 100);
        s_tsset[0] = 1; s_ts[0] = 16'd95;
        run_obs(8);
        chk("t3_valid_pattern", vpat(8), 16'h0020);
        chk("t3_time_at_head", obs_ts[5], 16'd100);

        // Wrap: inj=2 while sim_time is just below the wrap point.
        clr_sched();
        s_vld[0] = 1; s_desc[0] = mk_desc(0, 0, 0, 'h12, 2);
        s_tsset[0] = 1; s_ts[0] = 16'hFFFE;
        run_obs(7);
        chk("t3w_valid_pattern", vpat(7), 16'h0010);
        chk("t3w_time_at_head", obs_ts[4], 16'd2);

        // vc field 0xB selects VC 3; its full flag pulses 3 cycles mid-body.
        clr_sched();
        d = mk_desc(0, 2, 'hB, 'h44, 500);
        s_vld[0] = 1; s_desc[0] = d; s_tsset[0] = 1; s_ts[0] = 16'd500;
        for (int k = 0; k < W; k++) s_ofull[k] = {(k >= 4 && k <= 6), 3'($urandom_range(0, 7))};
        run_obs(11);
        chk("t4_valid_pattern", vpat(11), 16'h018C);
        for (int k = 4; k <= 7; k++) chk("t4_held_flit", obs_f[k], exp_flit(d, 2));

        // Fill the FIFO while every VC is full.
        for (int i = 0; i < 6; i++)
            f_desc[i] = mk_desc(1'($urandom_range(0, 1)), $urandom_range(0, 1),
                                $urandom_range(0, 15), i, int'(sim_time));
        acc = 0; fell = -1; rose = 0;
        tick();
        obuf_full = '1; packet_in_valid = 1; packet_in = f_desc[0];
        for (int c = 0; c < 100 && acc < 6; c++) begin
            @(negedge clock);
            if (packet_request) begin
                if (fell >= 0) rose = 1;
                acc++;
            end else if (fell < 0) fell = acc;
            tick();
            packet_in_valid = (acc < 6);
            packet_in = f_desc[(acc < 6) ? acc : 5];
            if (c >= 12) obuf_full = '0;
        end
        // One descriptor leaves the FIFO for the stalled head, so FIFO_DEPTH+1 get in.
        chk("t5_fill_depth", fell, FIFO_DEPTH + 1);
        chk("t5_reassert", rose, 1);
        chk("t5_all_accepted", acc, 6);
        drain("t5_drain");

        // Reset during the second body flit with two packets queued.
        clr_sched();
        for (int k = 0; k < 3; k++) begin
            s_vld[k] = 1;
            s_desc[k] = mk_desc(0, 2, 0, 'h50 + k, 3000);
        end
        s_tsset[0] = 1; s_ts[0] = 16'd3000;
        s_rst[4] = 1;
        run_obs(10);
        chk("t6_body2_present", obs_v[4], 1);
        chk("t6_post_valid", vpat(10) >> 5, 16'h0000);
        chk("t6_post_busy", obs_b[5], 0);
        chk("t6_post_req", obs_r[5], 1);

        // Random traffic with enable, full flags and timestamps varying.
        for (int c = 0; c < 400; c++) begin
            tick();
            enable = ($urandom_range(0, 9) != 0);
            packet_in_valid = 1'($urandom_range(0, 1));
            packet_in = mk_desc(1'($urandom_range(0, 1)), $urandom_range(0, 2),
                                $urandom_range(0, 15), $urandom_range(0, 255),
                                int'(sim_time) + int'($urandom_range(0, 12)) - 6);
            for (int v = 0; v < NVCS; v++) obuf_full[v] = ($urandom_range(0, 3) == 0);
        end
        drain("rand_drain");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
